// File: rtl/unpack_rq0_stream_if.sv
// Byte-in / coefficient-out stream bundle for the Rq0 ciphertext unpacker.
// The slave side is the unpacker; the master side is the producer and consumer around it.
interface unpack_rq0_stream_if #(
    parameter int LOGQ = 13
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] out_coef;
    logic [9:0]      out_idx;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_coef, out_idx, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_coef, out_idx, out_valid, out_last
    );
endinterface

// File: rtl/unpack_rq0_stream.sv
// Unpacks N-1 LOGQ-bit coefficients from a byte stream and rebuilds the last one from sum == 0 mod q.
// Latency: first coefficient one cycle after the second byte is accepted; byte and coefficient transfers never overlap.
// Backpressure: out_ready low freezes the output and stops byte intake. Optional feature macro: UNPACK_RQ0_PAD_CHECK_EN.
module unpack_rq0_stream #(
    parameter int N    = 701,
    parameter int LOGQ = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    unpack_rq0_stream_if.slave stream,
    output logic               busy,
    output logic               done
`ifdef UNPACK_RQ0_PAD_CHECK_EN
    ,
    output logic               pad_err
`endif
);
    localparam int BYTES    = ((N - 1) * LOGQ + 7) / 8;
    localparam int ACC_W    = LOGQ - 1 + 8;
    localparam int BITS_W   = $clog2(ACC_W + 1);
    localparam int PAD_BITS = BYTES * 8 - (N - 1) * LOGQ;

    localparam logic [BITS_W-1:0] LOGQ_B  = BITS_W'(LOGQ);
    localparam logic [BITS_W-1:0] EIGHT_B = BITS_W'(8);
    localparam logic [10:0]       BYTES_B = 11'(BYTES);
    localparam logic [9:0]        IDX_PEN = 10'(N - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_LAST,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt, acc_shift;
    logic [BITS_W-1:0] acc_bits, acc_bits_nxt;
    logic [10:0]       byte_cnt, byte_cnt_nxt;
    logic [9:0]        idx, idx_nxt;
    logic [LOGQ-1:0]   sum, sum_nxt;

    logic              in_rdy;
    logic              out_vld;
    logic              out_lst;
    logic [LOGQ-1:0]   coef;

`ifdef UNPACK_RQ0_PAD_CHECK_EN
    logic              pad_err_nxt;
`endif

    assign acc_shift = acc >> LOGQ;

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        acc_bits_nxt = acc_bits;
        byte_cnt_nxt = byte_cnt;
        idx_nxt      = idx;
        sum_nxt      = sum;
        in_rdy       = 1'b0;
        out_vld      = 1'b0;
        out_lst      = 1'b0;
        coef         = acc[LOGQ-1:0];
`ifdef UNPACK_RQ0_PAD_CHECK_EN
        pad_err_nxt  = pad_err;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_UNPACK;
                    acc_nxt      = '0;
                    acc_bits_nxt = '0;
                    byte_cnt_nxt = '0;
                    idx_nxt      = '0;
                    sum_nxt      = '0;
`ifdef UNPACK_RQ0_PAD_CHECK_EN
                    pad_err_nxt  = 1'b0;
`endif
                end
            end

            ST_UNPACK: begin
                // Intake stops as soon as a whole coefficient is buffered, so the two
                // handshakes are exclusive and the accumulator never exceeds ACC_W bits.
                in_rdy  = (acc_bits < LOGQ_B) && (byte_cnt < BYTES_B);
                out_vld = (acc_bits >= LOGQ_B);

                if (stream.in_valid && in_rdy) begin
                    acc_nxt      = acc | (ACC_W'(stream.in_data) << acc_bits);
                    acc_bits_nxt = acc_bits + EIGHT_B;
                    byte_cnt_nxt = byte_cnt + 11'd1;
                end

                if (out_vld && stream.out_ready) begin
                    acc_nxt      = acc_shift;
                    acc_bits_nxt = acc_bits - LOGQ_B;
                    sum_nxt      = sum + coef;
                    idx_nxt      = idx + 10'd1;
                    if (idx == IDX_PEN) begin
                        state_nxt = ST_LAST;
`ifdef UNPACK_RQ0_PAD_CHECK_EN
                        // Whatever is left after the final packed coefficient is padding.
                        if (acc_shift[PAD_BITS-1:0] != '0) begin
                            pad_err_nxt = 1'b1;
                        end
`endif
                    end
                end
            end

            ST_LAST: begin
                out_vld = 1'b1;
                out_lst = 1'b1;
                coef    = {LOGQ{1'b0}} - sum;
                if (stream.out_ready) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            acc_bits <= '0;
            byte_cnt <= '0;
            idx      <= '0;
            sum      <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            acc_bits <= acc_bits_nxt;
            byte_cnt <= byte_cnt_nxt;
            idx      <= idx_nxt;
            sum      <= sum_nxt;
        end
    end

`ifdef UNPACK_RQ0_PAD_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_err <= 1'b0;
        end else begin
            pad_err <= pad_err_nxt;
        end
    end
`endif

    assign stream.in_ready  = in_rdy;
    assign stream.out_valid = out_vld;
    assign stream.out_coef  = coef;
    assign stream.out_idx   = idx;
    assign stream.out_last  = out_lst;
    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
endmodule

// File: tb/tb_unpack_rq0_stream.sv
// Directed bench for unpack_rq0_stream: frames built in place, coefficients checked against a bit-level model
// and hand-computed constants; inputs driven and outputs sampled on the falling edge.
module tb_unpack_rq0_stream;
    localparam int N     = 701;
    localparam int LOGQ  = 13;
    localparam int BYTES = 1138;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
`ifdef UNPACK_RQ0_PAD_CHECK_EN
    logic pad_err;
`endif

    unpack_rq0_stream_if #(.LOGQ(LOGQ)) bus ();

    unpack_rq0_stream #(.N(N), .LOGQ(LOGQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stream (bus.slave),
        .busy   (busy),
        .done   (done)
`ifdef UNPACK_RQ0_PAD_CHECK_EN
        ,
        .pad_err(pad_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [7:0]      frame    [BYTES];
    logic [LOGQ-1:0] exp_coef [N];
    logic [LOGQ-1:0] got_coef [N];

    task automatic fill_frame(input logic [7:0] v);
        for (int i = 0; i < BYTES; i++) frame[i] = v;
    endtask

    // Independent bit-level model: coefficient i is stream bits 13i..13i+12, last is -sum mod 8192.
    task automatic compute_exp();
        logic [LOGQ-1:0] s;
        int pos;
        s = '0;
        for (int i = 0; i < N - 1; i++) begin
            for (int b = 0; b < LOGQ; b++) begin
                pos = i * LOGQ + b;
                exp_coef[i][b] = frame[pos / 8][pos % 8];
            end
            s = s + exp_coef[i];
        end
        exp_coef[N-1] = 13'd0 - s;
    endtask

    task automatic run_frame(input string tag, input int stall_idx);
        int ptr, got, dones, byte2_cyc, first_vld_cyc, stall_left;
        bit finished, stalling;
        logic [LOGQ-1:0] hold_coef;
        logic [9:0]      hold_idx;
        compute_exp();
        ptr = 0; got = 0; dones = 0; byte2_cyc = -1; first_vld_cyc = -1;
        stall_left = 10; finished = 0;
        hold_coef = '0; hold_idx = '0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dones > 0) begin
                tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL %s post_done: busy=%b done=%b, required 0/0", tag, busy, done);
                end
                finished = 1;
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                if (done === 1'b1) dones++;
                bus.in_valid = (ptr < BYTES);
                bus.in_data  = (ptr < BYTES) ? frame[ptr] : 8'h00;
                stalling = (stall_idx >= 0) && (bus.out_valid === 1'b1) &&
                           (int'(bus.out_idx) == stall_idx) && (stall_left > 0);
                if (stalling) begin
                    bus.out_ready = 1'b0;
                    start = 1'b1;
                    if (stall_left == 10) begin
                        hold_coef = bus.out_coef;
                        hold_idx  = bus.out_idx;
                    end else begin
                        tests++;
                        if (bus.out_coef !== hold_coef || bus.out_idx !== hold_idx) begin
                            fails++;
                            $display("FAIL %s stall_hold: coef=%0d idx=%0d, required %0d/%0d",
                                     tag, bus.out_coef, bus.out_idx, hold_coef, hold_idx);
                        end
                    end
                    tests++;
                    if (bus.in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL %s stall_in_ready: in_ready=%b, required 0", tag, bus.in_ready);
                    end
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
                if (bus.in_valid && bus.in_ready === 1'b1) begin
                    ptr++;
                    if (ptr == 2) byte2_cyc = c;
                end
                if (bus.out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = c;
                if (bus.out_valid === 1'b1 && bus.out_ready) begin
                    if (got < N) begin
                        got_coef[got] = bus.out_coef;
                        tests++;
                        if (bus.out_idx !== 10'(got) || bus.out_coef !== exp_coef[got] ||
                            bus.out_last !== (got == N - 1)) begin
                            fails++;
                            $display("FAIL %s coef[%0d]: idx=%0d coef=%0d last=%b, required idx=%0d coef=%0d last=%b",
                                     tag, got, bus.out_idx, bus.out_coef, bus.out_last,
                                     got, exp_coef[got], (got == N - 1));
                        end
                    end
                    got++;
                end
            end
        end
        tests++;
        if (!finished || got != N || dones != 1 || ptr != BYTES) begin
            fails++;
            $display("FAIL %s frame_end: finished=%0d coefs=%0d dones=%0d bytes=%0d, required 1/%0d/1/%0d",
                     tag, finished, got, dones, ptr, N, BYTES);
        end
        tests++;
        if (first_vld_cyc != byte2_cyc + 1) begin
            fails++;
            $display("FAIL %s latency: first out_valid at %0d, required %0d", tag, first_vld_cyc, byte2_cyc + 1);
        end
        if (stall_idx >= 0) begin
            tests++;
            if (stall_left != 0) begin
                fails++;
                $display("FAIL %s stall_seen: remaining=%0d, required 0", tag, stall_left);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b busy=%b done=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, busy, done);
        end
`ifdef UNPACK_RQ0_PAD_CHECK_EN
        tests++;
        if (pad_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_pad_err: pad_err=%b, required 0", pad_err);
        end
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_intake: in_ready=%b busy=%b out_valid=%b, required 0/0/0",
                     bus.in_ready, busy, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_all_zero();
        fill_frame(8'h00);
        run_frame("all_zero", -1);
        tests++;
        if (got_coef[N-1] !== 13'd0) begin
            fails++;
            $display("FAIL all_zero_last: coef=%0d, required 0", got_coef[N-1]);
        end
    endtask

    task automatic test_single_ff();
        fill_frame(8'h00);
        frame[0] = 8'hFF;
        frame[1] = 8'h1F;
        run_frame("ff1f", -1);
        tests++;
        if (got_coef[0] !== 13'd8191 || got_coef[1] !== 13'd0 || got_coef[N-1] !== 13'd1) begin
            fails++;
            $display("FAIL ff1f_values: c0=%0d c1=%0d c700=%0d, required 8191/0/1",
                     got_coef[0], got_coef[1], got_coef[N-1]);
        end
    endtask

    task automatic test_ramp();
        int pos;
        fill_frame(8'h00);
        for (int i = 0; i < N - 1; i++) begin
            for (int b = 0; b < LOGQ; b++) begin
                pos = i * LOGQ + b;
                frame[pos / 8][pos % 8] = 1'((i >> b) & 1);
            end
        end
        run_frame("ramp", -1);
        tests++;
        if (got_coef[699] !== 13'd699 || got_coef[N-1] !== 13'd1110) begin
            fails++;
            $display("FAIL ramp_values: c699=%0d c700=%0d, required 699/1110", got_coef[699], got_coef[N-1]);
        end
    endtask

    task automatic test_backpressure();
        fill_frame(8'h00);
        for (int i = 0; i < BYTES; i++) frame[i] = 8'(i * 37 + 11);
        run_frame("stall", 300);
    endtask

    task automatic test_pad();
        fill_frame(8'h00);
        frame[BYTES-1] = 8'hF0;
        run_frame("pad", -1);
`ifdef UNPACK_RQ0_PAD_CHECK_EN
        tests++;
        if (pad_err !== 1'b1) begin
            fails++;
            $display("FAIL pad_err_set: pad_err=%b, required 1", pad_err);
        end
        fill_frame(8'h00);
        run_frame("pad_clear", -1);
        tests++;
        if (pad_err !== 1'b0) begin
            fails++;
            $display("FAIL pad_err_clear: pad_err=%b, required 0", pad_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int ptr;
        ptr = 0;
        fill_frame(8'h00);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 3000 && ptr < 500; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'h5A;
            bus.out_ready = 1'b1;
            if (bus.in_ready === 1'b1) ptr++;
        end
        tests++;
        if (ptr != 500) begin
            fails++;
            $display("FAIL midreset_feed: bytes=%0d, required 500", ptr);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: busy=%b out_valid=%b in_ready=%b done=%b, required all 0",
                     busy, bus.out_valid, bus.in_ready, done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: out_valid=%b busy=%b, required 0/0", bus.out_valid, busy);
        end
        run_frame("after_reset", -1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        start = 1'b0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_zero();
        test_single_ff();
        test_ramp();
        test_backpressure();
        test_pad();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/unpack_rq0_stream.md
Name: unpack_rq0_stream

Overview:
- Inverse of the ciphertext packer.
- Accepts the packed NTRU-HRSS ciphertext as a byte stream and unpacks (N-1) LOGQ-bit coefficients.
- Reconstructs the final coefficient from the Rq0 property (coefficient sum = 0 mod q).
- Emits all N coefficients on a valid/ready stream. Sits at the decrypt-side front end, feeding the Rq multiplier.

Parameters:
- N, 701, polynomial length; N-1 coefficients are packed.
- LOGQ, 13, bits per coefficient; q = 2^LOGQ.
- BYTES, ((N-1)*LOGQ+7)/8 = 1138, packed length in bytes. Derived localparam, not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a new ciphertext. Sampled in IDLE only.
- in_data  in  8  packed byte. Byte k carries stream bits 8k..8k+7, LSB first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_coef  out  LOGQ  coefficient value mod q.
- out_idx  out  10  coefficient index, 0..N-1.
- out_valid  out  1  out_coef/out_idx valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with coefficient N-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after coefficient N-1 is accepted.
- pad_err  out  1  sticky padding error; present only with the optional feature.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; accumulator, bit count, byte count, idx and sum cleared.
  - in_ready, out_valid, out_last, busy, done, pad_err all 0.
  - Reset mid-operation abandons the frame; no partial output after reset.
- States:
  - IDLE: start=1 -> UNPACK; clears acc, acc_bits, byte_cnt, idx, sum, pad_err.
  - UNPACK, byte accept:
    - in_ready = (acc_bits < LOGQ) && (byte_cnt < BYTES).
    - On in_valid&&in_ready: acc |= in_data << acc_bits; acc_bits += 8; byte_cnt++.
    - Accumulator is 20 bits (max LOGQ-1+8).
  - UNPACK, coefficient output:
    - out_valid = (acc_bits >= LOGQ); out_coef = acc[LOGQ-1:0]; out_idx = idx.
    - On handshake: acc >>= LOGQ; acc_bits -= LOGQ; sum = (sum + out_coef) mod q; idx++.
    - Handshake with idx == N-2 -> LAST. At that point byte_cnt == BYTES and acc_bits == 4.
  - in_ready and out_valid are mutually exclusive by construction, so no simultaneous byte and coefficient transfer.
  - LAST:
    - out_valid=1, out_coef = (q - sum) mod q, out_idx = N-1, out_last=1.
    - On handshake -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Output registers are held stable while out_valid && !out_ready.
- start outside IDLE is ignored.
- in_ready=0 in IDLE, LAST and DONE; bytes offered there are not consumed.
- Latency: first out_valid is 1 cycle after the 2nd byte is accepted.
- Arithmetic: sum is LOGQ bits and wraps naturally mod 2^LOGQ. Negation is two's complement truncated to LOGQ bits; sum=0 gives 0.

Optional Feature:
- Macro: UNPACK_RQ0_PAD_CHECK_EN.
- Defined:
  - On the final coefficient handshake (idx N-2), the residual acc[3:0] (pad bits 9100..9103) is checked.
  - If nonzero, pad_err is set. It stays set until the next start or reset.
  - Output stream is unaffected.
- Undefined: pad_err port and logic absent; pad bits are silently discarded.

Test Plan:
- All 1138 bytes 0x00, out_ready=1 -> 701 coefficients, all 0. out_last only at idx 700; done pulses once; busy falls the cycle after done.
- Byte0=0xFF, byte1=0x1F, rest 0x00 -> coef0=8191, coefs 1..699=0, coef700=1.
- Packed coef i = i for i=0..699 -> out_coef equals out_idx for idx<700; coef700 = (-244650) mod 8192 = 1110.
- out_ready held low 10 cycles mid-frame with out_valid=1 -> out_coef/out_idx stable, in_ready=0, no bytes consumed; stream resumes intact.
- Last byte 0xF0 (pad nonzero), feature defined -> pad_err=1 after idx 699 handshake, all coefficients unchanged. Feature undefined -> identical stream, no pad_err port.
- rst_n=0 for 1 cycle after 500 bytes; then start with an all-zero frame -> clean 701-coefficient output, idx restarts at 0, no stale data.
